// File: rtl/tcdm_ecc_lane_bridge_pkg.sv
// Shared constants for the TCDM ECC lane bridge: lane parity width, header ECC
// width and the Hsiao(39,32) parity-check columns with a parity helper.
package tcdm_ecc_lane_bridge_pkg;

  localparam int unsigned ECC_LANE_BITS = 7;
  localparam int unsigned ECC_HDR_W     = 9;
  localparam int unsigned LANE_DW       = 32;

  // Column i is the parity signature of data bit i; all weight-3, all distinct,
  // so any single data error yields an odd syndrome that names its bit.
  localparam logic [ECC_LANE_BITS-1:0] HSIAO_COL [LANE_DW] = '{
    7'h07, 7'h0B, 7'h0D, 7'h0E, 7'h13, 7'h15, 7'h16, 7'h19,
    7'h1A, 7'h1C, 7'h23, 7'h25, 7'h26, 7'h29, 7'h2A, 7'h2C,
    7'h31, 7'h32, 7'h34, 7'h38, 7'h43, 7'h45, 7'h46, 7'h49,
    7'h4A, 7'h4C, 7'h51, 7'h52, 7'h54, 7'h58, 7'h61, 7'h62
  };

  function automatic logic [ECC_LANE_BITS-1:0] hsiao_parity(input logic [LANE_DW-1:0] d);
    logic [ECC_LANE_BITS-1:0] p;
    p = '0;
    for (int i = 0; i < LANE_DW; i++) begin
      if (d[i]) p = p ^ HSIAO_COL[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/tcdm_ecc_lane_bridge_if.sv
// Wide HCI core port: request/write side plus read response side.
interface tcdm_ecc_lane_bridge_if #(
  parameter int unsigned DW = 256,
  parameter int unsigned AW = 32,
  parameter int unsigned EW = 72
);
  logic          req;
  logic          gnt;
  logic [AW-1:0] add;
  logic          wen;
  logic [DW/8-1:0] be;
  logic [DW-1:0] data;
  logic [EW-1:0] ecc;
  logic          r_valid;
  logic [DW-1:0] r_data;
  logic [EW-1:0] r_ecc;
  logic          r_opc;
  logic          r_user;

  modport master (
    output req, add, wen, be, data, ecc,
    input  gnt, r_valid, r_data, r_ecc, r_opc, r_user
  );

  modport slave (
    input  req, add, wen, be, data, ecc,
    output gnt, r_valid, r_data, r_ecc, r_opc, r_user
  );
endinterface

// File: rtl/hsiao_ecc_dec.sv
// Hsiao(39,32) decoder: corrects a single error, flags odd / even non-zero syndromes.
module hsiao_ecc_dec
  import tcdm_ecc_lane_bridge_pkg::*;
#(
  parameter int unsigned DataWidth = 32
) (
  input  logic [DataWidth-1:0]     data_i,
  input  logic [ECC_LANE_BITS-1:0] parity_i,
  output logic [DataWidth-1:0]     data_o,
  output logic                     single_o,
  output logic                     double_o
);
  logic [ECC_LANE_BITS-1:0] syndrome;

  assign syndrome = parity_i ^ hsiao_parity(data_i);

  // Even syndromes never match a column, so double errors pass through raw.
  always_comb begin
    data_o = data_i;
    for (int i = 0; i < DataWidth; i++) begin
      if (syndrome == HSIAO_COL[i]) data_o[i] = ~data_i[i];
    end
  end

  assign single_o = ^syndrome;
  assign double_o = (|syndrome) & ~(^syndrome);
endmodule

// File: rtl/hsiao_ecc_enc.sv
// Hsiao(39,32) encoder: 7 parity bits for one 32-bit word.
module hsiao_ecc_enc
  import tcdm_ecc_lane_bridge_pkg::*;
#(
  parameter int unsigned DataWidth = 32
) (
  input  logic [DataWidth-1:0]     data_i,
  output logic [ECC_LANE_BITS-1:0] parity_o
);
  assign parity_o = hsiao_parity(data_i);
endmodule

// File: rtl/tcdm_ecc_lane_bridge.sv
// Splits one wide ECC-protected HCI port into MP 32-bit TCDM lanes, encoding
// read data per lane and correcting write data per lane with error counters.
module tcdm_ecc_lane_bridge
  import tcdm_ecc_lane_bridge_pkg::*;
#(
  parameter int unsigned DW      = 256,
  parameter int unsigned MP      = DW / 32,
  parameter int unsigned AW      = 32,
  parameter int unsigned EW      = 72,
  parameter int unsigned EHW     = ECC_HDR_W,
  parameter bit          USE_ECC = 1'b1,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  tcdm_ecc_lane_bridge_if.slave hci,
  output logic [MP-1:0]      lane_req_o,
  output logic [MP*AW-1:0]   lane_add_o,
  output logic [MP-1:0]      lane_wen_o,
  output logic [MP*4-1:0]    lane_be_o,
  output logic [MP*32-1:0]   lane_data_o,
  input  logic [MP-1:0]      lane_gnt_i,
  input  logic [MP-1:0]      lane_r_valid_i,
  input  logic [MP*32-1:0]   lane_r_data_i,
  output logic               err_single_o,
  output logic               err_double_o,
  input  logic               err_cnt_clr_i,
  output logic [CNT_W-1:0]   err_single_cnt_o,
  output logic [CNT_W-1:0]   err_double_cnt_o
);

  // Handshake: a beat transfers on a cycle with req & gnt; gnt is the AND of all
  // lane grants, so the wide request (and every lane request) stays up until all
  // lanes grant together. r_valid is likewise the AND of all lane valids.
  logic [MP-1:0] lane_single;
  logic [MP-1:0] lane_double;
  logic          wr_hs;
  logic          single_ev;
  logic          double_ev;
  logic          unused_ecc;

  assign hci.gnt     = &lane_gnt_i;
  assign hci.r_valid = &lane_r_valid_i;
  assign hci.r_data  = lane_r_data_i;
  assign hci.r_opc   = 1'b0;
  assign hci.r_user  = 1'b0;
  assign unused_ecc  = ^hci.ecc;

  for (genvar i = 0; i < MP; i++) begin : g_req
    assign lane_req_o[i]          = hci.req;
    assign lane_add_o[i*AW +: AW] = hci.add + AW'(4 * i);
    assign lane_wen_o[i]          = hci.wen;
    assign lane_be_o[i*4 +: 4]    = hci.be[i*4 +: 4];
  end

  if (USE_ECC) begin : g_ecc
    logic [MP*ECC_LANE_BITS-1:0] lane_par;
    for (genvar i = 0; i < MP; i++) begin : g_lane
      hsiao_ecc_enc #(.DataWidth(32)) u_enc (
        .data_i   (lane_r_data_i[32*i +: 32]),
        .parity_o (lane_par[ECC_LANE_BITS*i +: ECC_LANE_BITS])
      );
      hsiao_ecc_dec #(.DataWidth(32)) u_dec (
        .data_i   (hci.data[32*i +: 32]),
        .parity_i (hci.ecc[EHW + ECC_LANE_BITS*i +: ECC_LANE_BITS]),
        .data_o   (lane_data_o[32*i +: 32]),
        .single_o (lane_single[i]),
        .double_o (lane_double[i])
      );
    end
    assign hci.r_ecc = EW'(lane_par);
  end else begin : g_plain
    assign lane_data_o = hci.data;
    assign hci.r_ecc   = '0;
    assign lane_single = '0;
    assign lane_double = '0;
  end

  // Multiple bad lanes in one beat are reported once; double dominates single.
  assign wr_hs     = hci.req & hci.gnt & ~hci.wen;
  assign double_ev = wr_hs & (|lane_double);
  assign single_ev = wr_hs & (|lane_single) & ~(|lane_double);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_single_o     <= 1'b0;
      err_double_o     <= 1'b0;
      err_single_cnt_o <= '0;
      err_double_cnt_o <= '0;
    end else begin
      err_single_o <= single_ev;
      err_double_o <= double_ev;
      if (err_cnt_clr_i) begin
        err_single_cnt_o <= '0;
        err_double_cnt_o <= '0;
      end else begin
        if (single_ev && !(&err_single_cnt_o)) err_single_cnt_o <= err_single_cnt_o + 1'b1;
        if (double_ev && !(&err_double_cnt_o)) err_double_cnt_o <= err_double_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tcdm_ecc_lane_bridge.sv
// Directed bench for tcdm_ecc_lane_bridge with a per-cycle behavioural model
// and hand-computed literal checkpoints.
module tb_tcdm_ecc_lane_bridge;

  localparam int DW = 256, MP = 8, AW = 32, EW = 72, EHW = 9, CNT_W = 4;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [MP-1:0]    lane_req, lane_wen, lane_gnt, lane_r_valid;
  logic [MP*AW-1:0] lane_add;
  logic [MP*4-1:0]  lane_be;
  logic [MP*32-1:0] lane_data, lane_r_data;
  logic             err_single, err_double, clr;
  logic [CNT_W-1:0] scnt, dcnt;

  // Stimulus description: golden lane words and injected flips (data / parity)
  logic [31:0] gold  [MP];
  logic [31:0] dmask [MP];
  logic [6:0]  pmask [MP];

  int checks = 0, errors = 0;

  tcdm_ecc_lane_bridge_if #(.DW(DW), .AW(AW), .EW(EW)) bus ();

  tcdm_ecc_lane_bridge #(.DW(DW), .MP(MP), .AW(AW), .EW(EW), .EHW(EHW),
                         .USE_ECC(1'b1), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .hci(bus.slave),
    .lane_req_o(lane_req), .lane_add_o(lane_add), .lane_wen_o(lane_wen),
    .lane_be_o(lane_be), .lane_data_o(lane_data), .lane_gnt_i(lane_gnt),
    .lane_r_valid_i(lane_r_valid), .lane_r_data_i(lane_r_data),
    .err_single_o(err_single), .err_double_o(err_double), .err_cnt_clr_i(clr),
    .err_single_cnt_o(scnt), .err_double_cnt_o(dcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Code columns = the first 32 weight-3 values of 7 bits in ascending order.
  function automatic logic [6:0] model_parity(input logic [31:0] d);
    logic [6:0] p;
    int k;
    p = '0;
    k = 0;
    for (int v = 1; v < 128; v++) begin
      if ($countones(v) == 3 && k < 32) begin
        if (d[k]) p = p ^ 7'(v);
        k++;
      end
    end
    return p;
  endfunction

  function automatic int lane_flips(input int i);
    return $countones(dmask[i]) + $countones(pmask[i]);
  endfunction

  // ---------------- behavioural model of the registered error logic
  logic m_single, m_double;
  int   m_scnt, m_dcnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_single <= 1'b0; m_double <= 1'b0; m_scnt <= 0; m_dcnt <= 0;
    end else begin
      bit hs, anys, anyd;
      hs = bus.req && (lane_gnt == '1) && !bus.wen;
      anys = 1'b0; anyd = 1'b0;
      for (int i = 0; i < MP; i++) begin
        if (lane_flips(i) == 1) anys = 1'b1;
        if (lane_flips(i) == 2) anyd = 1'b1;
      end
      m_single <= hs && anys && !anyd;
      m_double <= hs && anyd;
      if (clr) begin
        m_scnt <= 0; m_dcnt <= 0;
      end else begin
        if (hs && anys && !anyd && m_scnt < CMAX) m_scnt <= m_scnt + 1;
        if (hs && anyd && m_dcnt < CMAX) m_dcnt <= m_dcnt + 1;
      end
    end
  end

  // ---------------- per-cycle compare
  always @(negedge clk) begin
    logic [255:0] exp_rdata, exp_ldata;
    logic [71:0]  exp_recc;
    for (int i = 0; i < MP; i++) begin
      exp_rdata[32*i +: 32] = lane_r_data[32*i +: 32];
      exp_ldata[32*i +: 32] = (lane_flips(i) <= 1) ? gold[i] : (gold[i] ^ dmask[i]);
    end
    exp_recc = '0;
    for (int i = 0; i < MP; i++) exp_recc[7*i +: 7] = model_parity(lane_r_data[32*i +: 32]);
    chk("gnt", 256'(bus.gnt), 256'(lane_gnt == '1));
    chk("r_valid", 256'(bus.r_valid), 256'(lane_r_valid == '1));
    chk("lane_req", 256'(lane_req), 256'({MP{bus.req}}));
    chk("lane_wen", 256'(lane_wen), 256'({MP{bus.wen}}));
    chk("lane_be", 256'(lane_be), 256'(bus.be));
    for (int i = 0; i < MP; i++)
      chk($sformatf("lane_add%0d", i), 256'(lane_add[32*i +: 32]), 256'(32'(bus.add + 32'(4 * i))));
    chk("r_data", bus.r_data, exp_rdata);
    chk("r_ecc", 256'(bus.r_ecc), 256'(exp_recc));
    chk("r_opc_user", 256'({bus.r_opc, bus.r_user}), 256'(0));
    if (bus.req && !bus.wen) chk("lane_data", lane_data, exp_ldata);
    chk("err_single", 256'(err_single), 256'(m_single));
    chk("err_double", 256'(err_double), 256'(m_double));
    chk("single_cnt", 256'(scnt), 256'(m_scnt));
    chk("double_cnt", 256'(dcnt), 256'(m_dcnt));
  end

  // ---------------- driver tasks
  task automatic apply_write();
    bus.ecc = '0;
    for (int i = 0; i < MP; i++) begin
      bus.data[32*i +: 32] = gold[i] ^ dmask[i];
      bus.ecc[EHW + 7*i +: 7] = model_parity(gold[i]) ^ pmask[i];
    end
  endtask

  task automatic clear_masks();
    for (int i = 0; i < MP; i++) begin
      dmask[i] = '0; pmask[i] = '0;
    end
  endtask

  task automatic set_idle();
    bus.req = 1'b0; bus.wen = 1'b1; bus.add = '0; bus.be = '0;
    lane_gnt = '1; lane_r_valid = '0; clr = 1'b0;
    clear_masks();
    apply_write();
  endtask

  task automatic setup_write(input logic [31:0] addr);
    bus.req = 1'b1; bus.wen = 1'b0; bus.add = addr; bus.be = '1;
    apply_write();
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence
  initial begin
    for (int i = 0; i < MP; i++) gold[i] = 32'hA5A5_0000 + 32'(i * 32'h1111);
    lane_r_data = '0;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_single_cnt", 256'(scnt), 256'(0));
    chk("rst_double_cnt", 256'(dcnt), 256'(0));
    rst_n = 1'b1;

    // Read: all lanes valid
    next_cycle();
    bus.req = 1'b1; bus.wen = 1'b1; lane_r_valid = '1;
    for (int i = 0; i < MP; i++) lane_r_data[32*i +: 32] = 32'h1000_0000 + 32'(i);
    @(negedge clk);
    chk("lit_rdata_w1", 256'(bus.r_data[63:32]), 256'(32'h1000_0001));
    chk("lit_recc_l0", 256'(bus.r_ecc[6:0]), 256'(7'h54));
    chk("lit_recc_l1", 256'(bus.r_ecc[13:7]), 256'(7'h53));
    chk("lit_recc_hi", 256'(bus.r_ecc[71:56]), 256'(0));
    chk("lit_r_valid", 256'(bus.r_valid), 256'(1));

    // Clean write, address fan-out
    next_cycle();
    lane_r_valid = '0;
    setup_write(32'h1C01_0000);
    @(negedge clk);
    chk("lit_lane_add7", 256'(lane_add[7*32 +: 32]), 256'(32'h1C01_001C));
    chk("lit_lane_be", 256'(lane_be), 256'(32'hFFFF_FFFF));

    // Single error: lane 3 data bit 5
    next_cycle();
    gold[3] = 32'hDEADBEEF; dmask[3] = 32'h20;
    setup_write(32'h0000_0100);
    @(negedge clk);
    chk("lit_corr_l3", 256'(lane_data[3*32 +: 32]), 256'(32'hDEADBEEF));
    next_cycle();
    set_idle();
    @(negedge clk);
    chk("lit_single_pulse", 256'(err_single), 256'(1));
    chk("lit_single_cnt1", 256'(scnt), 256'(1));
    chk("lit_no_double", 256'(err_double), 256'(0));
    next_cycle();
    @(negedge clk);
    chk("lit_single_drop", 256'(err_single), 256'(0));

    // Double error: lane 0 bits 0 and 1, raw forwarded
    next_cycle();
    gold[0] = 32'h0; dmask[0] = 32'h3;
    setup_write(32'h0000_0200);
    @(negedge clk);
    chk("lit_raw_l0", 256'(lane_data[31:0]), 256'(32'h3));
    next_cycle();
    set_idle();
    @(negedge clk);
    chk("lit_double_pulse", 256'(err_double), 256'(1));
    chk("lit_double_cnt1", 256'(dcnt), 256'(1));
    chk("lit_single_hold", 256'(scnt), 256'(1));

    // Single error in a parity bit of lane 5: data untouched, still counted
    next_cycle();
    pmask[5] = 7'h10;
    setup_write(32'h0000_0300);
    next_cycle();
    set_idle();
    @(negedge clk);
    chk("lit_single_cnt2", 256'(scnt), 256'(2));

    // Partial grant for 3 cycles, error must wait for the handshake
    next_cycle();
    dmask[2] = 32'h8000_0000;
    setup_write(32'h0000_0400);
    lane_gnt = 8'hFE;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("lit_gnt_low", 256'(bus.gnt), 256'(0));
      chk("lit_lane_req_held", 256'(lane_req), 256'(8'hFF));
      if (c > 0) chk("lit_no_flag_wait", 256'(err_single), 256'(0));
      next_cycle();
    end
    lane_gnt = 8'hFF;
    @(negedge clk);
    chk("lit_gnt_high", 256'(bus.gnt), 256'(1));
    next_cycle();
    set_idle();
    @(negedge clk);
    chk("lit_single_after_gnt", 256'(err_single), 256'(1));
    chk("lit_single_cnt3", 256'(scnt), 256'(3));

    // Saturation: 14 more single-error beats (3 + 14 > 15)
    next_cycle();
    dmask[1] = 32'h80;
    setup_write(32'h0000_0500);
    repeat (14) next_cycle();
    set_idle();
    @(negedge clk);
    chk("lit_single_sat", 256'(scnt), 256'(CMAX));
    chk("lit_double_keep", 256'(dcnt), 256'(1));

    // Clear together with an error: clear wins
    next_cycle();
    dmask[6] = 32'h1;
    setup_write(32'h0000_0600);
    clr = 1'b1;
    next_cycle();
    set_idle();
    @(negedge clk);
    chk("lit_clr_single", 256'(scnt), 256'(0));
    chk("lit_clr_double", 256'(dcnt), 256'(0));
    chk("lit_clr_flag", 256'(err_single), 256'(1));

    // Reset mid-burst
    next_cycle();
    dmask[4] = 32'h4;
    setup_write(32'h0000_0700);
    repeat (3) next_cycle();
    dmask[4] = 32'h0; dmask[7] = 32'h11;
    apply_write();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("lit_rst_single", 256'(err_single), 256'(0));
    chk("lit_rst_double", 256'(err_double), 256'(0));
    chk("lit_rst_scnt", 256'(scnt), 256'(0));
    chk("lit_rst_dcnt", 256'(dcnt), 256'(0));
    next_cycle();
    set_idle();
    rst_n = 1'b1;
    repeat (2) next_cycle();
    @(negedge clk);
    chk("lit_post_rst_cnt", 256'(scnt), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
